// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, resolver state encoding and byte-lane helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package eth_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    // Ethernet / ARP header constants, as they appear on the wire (big-endian)
    localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'h06;
    localparam logic [7:0]  ARP_PLEN         = 8'h04;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RESOLVED = 3'd3,
        ST_FAIL     = 3'd4
    } arp_state_t;

    // Lane 0 carries the first wire byte, so a big-endian field lands byte-reversed in rxd.
    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [47:0] mac_lanes(input logic [47:0] m);
        return {m[7:0], m[15:8], m[23:16], m[31:24], m[39:32], m[47:40]};
    endfunction

endpackage

// File: rtl/arp_resolver_if.sv
// Bundle of RX data, configuration and resolver status between the resolver and its user.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface arp_resolver_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        req_arp;
    logic [47:0] own_mac;
    logic [31:0] own_ip;
    logic [31:0] gw_ip;
    logic        arp_req;
    logic [47:0] dst_mac;
    logic        dst_mac_valid;
    logic        arp_busy;
    logic        arp_fail;
    logic [15:0] reply_count;

    modport master (
        output xgmii_rxd, xgmii_rxc, req_arp, own_mac, own_ip, gw_ip,
        input  arp_req, dst_mac, dst_mac_valid, arp_busy, arp_fail, reply_count
    );

    modport slave (
        input  xgmii_rxd, xgmii_rxc, req_arp, own_mac, own_ip, gw_ip,
        output arp_req, dst_mac, dst_mac_valid, arp_busy, arp_fail, reply_count
    );
endinterface

// File: rtl/arp_reply_parser.sv
// Checks XGMII frames word by word for an ARP reply from gw_ip to own_ip; captures SHA.
// Latency: reply_ok is combinational on the FD word; sha is registered from words 3/4.
// Backpressure: none; follows the RX stream every cycle.
module arp_reply_parser
    import eth_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic [47:0] own_mac,
    input  logic [31:0] own_ip,
    input  logic [31:0] gw_ip,
    output logic        reply_ok,
    output logic [47:0] sha
);
    logic        r_active;
    logic        r_rej;
    logic [2:0]  r_idx;
    logic [47:0] r_sha;
    logic        w_start;
    logic        w_term;
    logic        w_err;
    logic        w_fail;

    assign w_start = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == XGMII_START);

    // Find terminate and error control characters anywhere in the word
    always_comb begin
        w_term = 1'b0;
        w_err  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == XGMII_TERM))  w_term = 1'b1;
            if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == XGMII_ERROR)) w_err  = 1'b1;
        end
    end

    // Per-word header checks; control bytes before the TPA tail spoil the frame
    always_comb begin
        w_fail = 1'b0;
        if ((r_idx < 3'd6) && (xgmii_rxc != 8'h00)) w_fail = 1'b1;
        case (r_idx)
            3'd1: if ((xgmii_rxd[47:0] != mac_lanes(own_mac)) &&
                      (xgmii_rxd[47:0] != 48'hFFFF_FFFF_FFFF)) w_fail = 1'b1;
            3'd2: if ((xgmii_rxd[47:32] != swap16(ETH_TYPE_ARP)) ||
                      (xgmii_rxd[63:48] != swap16(ARP_HTYPE_ETH))) w_fail = 1'b1;
            3'd3: if ((xgmii_rxd[15:0]  != swap16(ARP_PTYPE_IPV4)) ||
                      (xgmii_rxd[23:16] != ARP_HLEN) ||
                      (xgmii_rxd[31:24] != ARP_PLEN) ||
                      (xgmii_rxd[47:32] != swap16(ARP_OPER_REPLY))) w_fail = 1'b1;
            3'd4: if (xgmii_rxd[63:32] != swap32(gw_ip)) w_fail = 1'b1;
            3'd5: if (xgmii_rxd[63:48] != swap16(own_ip[31:16])) w_fail = 1'b1;
            3'd6: if ((xgmii_rxc[1:0] != 2'b00) ||
                      (xgmii_rxd[15:0] != swap16(own_ip[15:0]))) w_fail = 1'b1;
            default: ;
        endcase
    end

    // Frame tracking: FB restarts at word 1 next cycle, index saturates at 7, FD closes the frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_active <= 1'b0;
            r_rej    <= 1'b0;
            r_idx    <= 3'd0;
            r_sha    <= 48'h0;
        end else if (w_start) begin
            r_active <= 1'b1;
            r_rej    <= 1'b0;
            r_idx    <= 3'd1;
        end else if (r_active) begin
            r_rej <= r_rej | w_fail | w_err;
            if (w_term)          r_active <= 1'b0;
            if (r_idx != 3'd7)   r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd3)   r_sha[47:32] <= swap16(xgmii_rxd[63:48]);
            if (r_idx == 3'd4)   r_sha[31:0]  <= swap32(xgmii_rxd[31:0]);
        end
    end

    assign reply_ok = r_active && !w_start && w_term && !r_rej && !w_fail && !w_err &&
                      (r_idx >= 3'd6);
    assign sha      = r_sha;

endmodule

// File: rtl/arp_resolver.sv
// Resolves the gateway MAC: issues ARP requests with timeout/retry and latches the reply SHA.
// Latency: dst_mac_valid rises the cycle after the FD word of an accepted reply.
// Backpressure: none; arp_req is a single-cycle pulse the TX side must honour.
module arp_resolver
    import eth_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 156250000,
    parameter int MAX_RETRY      = 3
)
(
    input  logic           sys_clk,
    input  logic           sys_rst,
    arp_resolver_if.slave  bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX    = AW'(MAX_RETRY);

    arp_state_t   r_state;
    arp_state_t   w_next;
    logic [TW-1:0] r_timer;
    logic [AW-1:0] r_att;
    logic [47:0]  r_dst_mac;
    logic         r_dst_vld;
    logic [15:0]  r_reply_cnt;
    logic         w_reply_ok;
    logic [47:0]  w_sha;
    logic         w_load;
    logic         w_resolve;

    arp_reply_parser u_parser (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .xgmii_rxd (bus.xgmii_rxd),
        .xgmii_rxc (bus.xgmii_rxc),
        .own_mac   (bus.own_mac),
        .own_ip    (bus.own_ip),
        .gw_ip     (bus.gw_ip),
        .reply_ok  (w_reply_ok),
        .sha       (w_sha)
    );

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next state; dropping req_arp always returns to IDLE, a reply beats a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_resolve = 1'b0;
        if (!bus.req_arp) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_REQ;
                ST_REQ: begin
                    w_load = 1'b1;
                    w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_reply_ok) begin
                        w_resolve = 1'b1;
                        w_next    = ST_RESOLVED;
                    end else if (r_timer == '0) begin
                        w_next = (r_att >= ATT_MAX) ? ST_FAIL : ST_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer, attempt count, resolved address and reply counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_timer     <= '0;
            r_att       <= '0;
            r_dst_mac   <= 48'hFFFF_FFFF_FFFF;
            r_dst_vld   <= 1'b0;
            r_reply_cnt <= 16'h0;
        end else begin
            if (w_load)                                   r_timer <= TIMER_LOAD;
            else if (r_state == ST_WAIT && r_timer != '0) r_timer <= r_timer - TW'(1);

            if (w_next == ST_IDLE) r_att <= '0;
            else if (w_load)       r_att <= r_att + AW'(1);

            if (w_resolve) begin
                r_dst_mac <= w_sha;
                r_dst_vld <= 1'b1;
            end

            if (w_reply_ok && (r_reply_cnt != 16'hFFFF)) r_reply_cnt <= r_reply_cnt + 16'd1;
        end
    end

    assign bus.arp_req       = (r_state == ST_REQ);
    assign bus.arp_busy      = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign bus.arp_fail      = (r_state == ST_FAIL);
    assign bus.dst_mac       = r_dst_mac;
    assign bus.dst_mac_valid = r_dst_vld;
    assign bus.reply_count   = r_reply_cnt;

endmodule

// File: doc/arp_resolver.md
ARP_RESOLVER -- requirements
Module: arp_resolver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 156250000: wait-for-reply window per attempt, in sys_clk cycles (1 s at 156.25 MHz).
REQ-002 Parameter MAX_RETRY, default 3: number of ARP requests issued before declaring failure.
REQ-003 sys_clk  input  1  single clock for all logic; one clock; reset is asynchronous and active-high.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 xgmii_rxd  input  64  XGMII receive data; lane 0 = rxd[7:0] = first byte on the wire.
REQ-006 xgmii_rxc  input  8  XGMII receive control, one bit per lane.
REQ-007 req_arp  input  1  level; high = resolve the gateway MAC; low = idle.
REQ-008 own_mac  input  48  local MAC address.
REQ-009 own_ip  input  32  local IPv4 address; a.b.c.d with a in bits [31:24].
REQ-010 gw_ip  input  32  gateway IPv4 address to resolve.
REQ-011 arp_req  output  1  one-cycle pulse; the TX generator shall send one ARP request per pulse.
REQ-012 dst_mac  output  48  resolved gateway MAC.
REQ-013 dst_mac_valid  output  1  high while dst_mac holds a resolved address.
REQ-014 arp_busy  output  1  high in the REQ and WAIT states.
REQ-015 arp_fail  output  1  high in the FAIL state.
REQ-016 reply_count  output  16  count of accepted ARP replies; saturates at 16'hFFFF.

Function
REQ-017 Parser frame start: rxc=8'h01 and rxd[7:0]=8'hFB. This resets the word index to 0. A start seen mid-frame aborts the frame in progress and begins a new one.
REQ-018 Parser field checks, by word index (byte offsets counted after the SFD):
- word1: destination MAC = own_mac or ff:ff:ff:ff:ff:ff.
- word2: lanes 4-5 = 08,06; lanes 6-7 = 00,01.
- word3: lanes 0-3 = 08,00,06,04; lanes 4-5 = 00,02; lanes 6-7 = SHA[47:32].
- word4: lanes 0-3 = SHA[31:0]; lanes 4-7 = SPA, which shall equal gw_ip.
- word6: lanes 0-1 = TPA[15:0]; together with word5 lanes 6-7, TPA shall equal own_ip.
REQ-019 Any failed check marks the frame rejected. Any data word with rxc≠8'h00 before word6 rejects the frame.
REQ-020 Frame end: the first word containing control byte FD. The frame shall be accepted only if it is unrejected, reached word6, and contained no FE control byte in any word. Acceptance asserts a one-cycle internal reply_ok with the captured SHA.
REQ-021 Word index saturates at 7; frames longer than 8 words are still eligible for acceptance.
REQ-022 Resolver states: IDLE, REQ, WAIT, RESOLVED, FAIL.
- IDLE→REQ when req_arp=1.
- REQ: arp_req=1 for exactly one cycle; load the timer with TIMEOUT_CYCLES-1; increment the attempt count; →WAIT.
- WAIT→RESOLVED on reply_ok: dst_mac←SHA, dst_mac_valid←1.
- WAIT, timer=0, attempts<MAX_RETRY: →REQ.
- WAIT, timer=0, attempts=MAX_RETRY: →FAIL.
- Any state, req_arp=0: →IDLE next cycle; attempts cleared; dst_mac and dst_mac_valid retained.
- RESOLVED and FAIL hold until req_arp=0.
REQ-023 reply_ok and timer expiry in the same cycle: reply_ok wins (→RESOLVED).
REQ-024 reply_ok in IDLE, REQ, RESOLVED or FAIL: reply_count increments; dst_mac is not updated.
REQ-025 reply_count increments on every reply_ok regardless of state.
REQ-026 Latency: dst_mac_valid rises one cycle after the cycle that presents the FD word of an accepted frame.

Reset
REQ-027 sys_rst asynchronously forces: state IDLE, attempts 0, timer 0, parser idle, arp_req 0, dst_mac 48'hFFFFFFFFFFFF, dst_mac_valid 0, arp_busy 0, arp_fail 0, reply_count 0.
REQ-028 Reset asserted mid-frame or mid-WAIT discards all progress. After release, a frame already in flight (no new FB seen) shall not be accepted.

Structure
REQ-029 A shared package eth_pkg holds:
- XGMII characters: START FB, TERM FD, ERROR FE, IDLE 07.
- Ethertype ARP 0806, ARP opcodes, and the resolver state encoding.
REQ-030 The per-frame checker shall be a sub-module arp_reply_parser (outputs reply_ok, sha[47:0]). The resolver FSM, timer and counters stay in arp_resolver.

Verification
REQ-031 Reset; req_arp=1 with no RX traffic, TIMEOUT_CYCLES=100 -> arp_req pulses at cycles 1, 102, 203; arp_fail=1 from cycle 304; dst_mac stays FFFFFFFFFFFF.
REQ-032 Reply SHA=00:37:76:00:01:01, SPA=gw_ip=10.0.20.1, TPA=own_ip=10.0.20.105 during WAIT -> dst_mac=003776000101, dst_mac_valid=1 one cycle after the FD word, reply_count=1.
REQ-033 Same reply with oper=0001, then with an FE in word7, then with SPA=10.0.20.2 -> none accepted; reply_count=0; state remains WAIT.
REQ-034 New FB start injected at word3 of a valid reply, followed by a complete valid reply -> exactly one acceptance.
REQ-035 Valid reply whose FD word coincides with timer=0 -> RESOLVED, no further arp_req; then req_arp=0 -> IDLE with dst_mac retained and valid=1.
REQ-036 sys_rst pulsed mid-WAIT during a reply -> all outputs at reset values; the remainder of that reply is ignored.
